// File: rtl/vector_sum_reduce.sv
// vector_sum_reduce: serial reduction of a signed product vector to one
// saturated scalar sum. One element is added per clock into a widened
// accumulator; the clamped result is held on a valid/ready output until taken.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. in_valid is ignored while in_ready=0 (the producer keeps holding
// it). out_valid, out_sum and out_sat stay asserted and stable until the edge
// where out_ready is also high.
module vector_sum_reduce #(
   parameter int VEC_LEN = 5,
   parameter int DATA_W  = 32,
   parameter int ACC_W   = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_vec [0:VEC_LEN-1],
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_sum,
   output logic                     out_sat
);

   // Index register is at least one bit wide so VEC_LEN=1 still elaborates.
   localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

   // Output clamp bounds in DATA_W, sign-extended to ACC_W for comparison.
   localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0]  ACC_MAX = ACC_W'(OUT_MAX);
   localparam logic signed [ACC_W-1:0]  ACC_MIN = ACC_W'(OUT_MIN);

   // The accumulator must hold VEC_LEN full-scale elements without wrapping.
   generate
      if (VEC_LEN < 1) begin : g_len_check
         $error("vector_sum_reduce: VEC_LEN must be at least 1");
      end
      if (ACC_W < DATA_W + $clog2(VEC_LEN)) begin : g_acc_w_check
         $error("vector_sum_reduce: ACC_W must be >= DATA_W + clog2(VEC_LEN)");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                     state;
   logic signed [DATA_W-1:0]   vec [0:VEC_LEN-1];
   logic signed [ACC_W-1:0]    acc;
   logic [IDX_W-1:0]           idx;

   logic signed [ACC_W-1:0]    elem_ext;
   logic signed [ACC_W-1:0]    acc_next;
   logic signed [DATA_W-1:0]   sat_sum;
   logic                       sat_flag;

   // Next accumulator value and its clamped DATA_W form.
   always_comb begin
      elem_ext = ACC_W'(vec[idx]);
      acc_next = acc + elem_ext;
      sat_sum  = acc_next[DATA_W-1:0];
      sat_flag = 1'b0;
      if (acc_next > ACC_MAX) begin
         sat_sum  = OUT_MAX;
         sat_flag = 1'b1;
      end else if (acc_next < ACC_MIN) begin
         sat_sum  = OUT_MIN;
         sat_flag = 1'b1;
      end
   end

   // Control FSM with registered handshake outputs and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_sat   <= 1'b0;
         acc       <= '0;
         idx       <= '0;
         for (int i = 0; i < VEC_LEN; i++) begin
            vec[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  for (int i = 0; i < VEC_LEN; i++) begin
                     vec[i] <= in_vec[i];
                  end
                  acc      <= '0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               acc <= acc_next;
               idx <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  out_sum   <= sat_sum;
                  out_sat   <= sat_flag;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
